// File: rtl/host_seq.sv
// Host-side run sequencer: preloads data memory, launches the processor, waits for
// completion (with timeout), then streams result words back out.
module host_seq #(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter int            LOAD_N    = 4,
    parameter int            READ_N    = 2,
    parameter logic [AW-1:0] LOAD_BASE = '0,
    parameter logic [AW-1:0] RES_BASE  = '0,
    parameter int            TIMEOUT   = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          req,
    input  logic          done,
    output logic          res_valid,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_data,
    output logic          busy,
    output logic          run_ok,
    output logic          timeout_err,
    output logic [15:0]   cycle_count,
    output logic [2:0]    dbg_state
);

    // Handshake: start is a one-cycle request sampled only in IDLE; req is a one-cycle
    // launch pulse; done is a level sampled only in RUN; res_valid qualifies res_addr/res_data.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_READ   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [15:0] LOAD_LAST = 16'(LOAD_N - 1);
    localparam logic [15:0] READ_LAST = 16'(READ_N);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] cycle_count_n;
    logic        run_ok_n, timeout_err_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cycle_count <= '0;
            run_ok      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cycle_count <= cycle_count_n;
            run_ok      <= run_ok_n;
            timeout_err <= timeout_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        cycle_count_n = cycle_count;
        run_ok_n      = run_ok;
        timeout_err_n = timeout_err;
        src_addr      = '0;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = '0;
        req           = 1'b0;
        res_valid     = 1'b0;
        res_addr      = '0;
        res_data      = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    run_ok_n      = 1'b0;
                    timeout_err_n = 1'b0;
                    cnt_n         = '0;
                    state_n       = (LOAD_N == 0) ? S_LAUNCH : S_LOAD;
                end
            end
            S_LOAD: begin
                mem_wr_en   = 1'b1;
                src_addr    = AW'(cnt);
                mem_addr    = LOAD_BASE + AW'(cnt);
                mem_wr_data = src_data;
                if (cnt == LOAD_LAST) begin
                    cnt_n   = '0;
                    state_n = S_LAUNCH;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_LAUNCH: begin
                req           = 1'b1;
                cycle_count_n = '0;
                cnt_n         = '0;
                state_n       = S_RUN;
            end
            S_RUN: begin
                if (cycle_count != 16'hFFFF)
                    cycle_count_n = cycle_count + 16'd1;
                // done takes priority over an expiring timeout in the same cycle
                if (done) begin
                    state_n = S_READ;
                end else if (cycle_count >= TO_LAST) begin
                    timeout_err_n = 1'b1;
                    state_n       = S_FINISH;
                end
            end
            S_READ: begin
                // address k goes out in step k; its word returns one step later
                if (cnt < READ_LAST)
                    mem_addr = RES_BASE + AW'(cnt);
                if (cnt != 16'd0) begin
                    res_valid = 1'b1;
                    res_addr  = RES_BASE + AW'(cnt) - AW'(1);
                    res_data  = mem_rd_data;
                end
                if (cnt == READ_LAST) begin
                    cnt_n   = '0;
                    state_n = S_FINISH;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_FINISH: begin
                run_ok_n = ~timeout_err;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_host_seq.sv
// Directed bench for host_seq: load/launch/run/read sequences, timeout, done-vs-timeout
// tie, start while busy, asynchronous reset mid-load and load-address wrap.
module tb_host_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  src_addr, src_data, mem_addr, mem_wr_data, mem_rd_data, res_addr, res_data;
    logic        mem_wr_en, req, res_valid, busy, run_ok, timeout_err;
    logic [15:0] cycle_count;
    logic [2:0]  dbg_state;

    logic        start_w = 1'b0;
    logic        done_w = 1'b0;
    logic [7:0]  mem_rd_data_w = 8'h00;
    logic [7:0]  src_addr_w, src_data_w, mem_addr_w, mem_wr_data_w, res_addr_w, res_data_w;
    logic        mem_wr_en_w, req_w, res_valid_w, busy_w, run_ok_w, timeout_err_w;
    logic [15:0] cycle_count_w;
    logic [2:0]  dbg_state_w;

    host_seq #(.DW(8), .AW(8), .LOAD_N(4), .READ_N(2), .LOAD_BASE(8'h00),
               .RES_BASE(8'h00), .TIMEOUT(10)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .src_data(src_data),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .req(req), .done(done),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .run_ok(run_ok), .timeout_err(timeout_err),
        .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    host_seq #(.DW(8), .AW(8), .LOAD_N(4), .READ_N(2), .LOAD_BASE(8'hFE),
               .RES_BASE(8'h00), .TIMEOUT(10)) u_wrap (
        .clk(clk), .reset(reset), .start(start_w),
        .src_addr(src_addr_w), .src_data(src_data_w),
        .mem_wr_en(mem_wr_en_w), .mem_addr(mem_addr_w), .mem_wr_data(mem_wr_data_w),
        .mem_rd_data(mem_rd_data_w), .req(req_w), .done(done_w),
        .res_valid(res_valid_w), .res_addr(res_addr_w), .res_data(res_data_w),
        .busy(busy_w), .run_ok(run_ok_w), .timeout_err(timeout_err_w),
        .cycle_count(cycle_count_w), .dbg_state(dbg_state_w)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- host table and data memory model ----------------
    logic [7:0] src_tab [4];
    logic [7:0] mem [256];
    assign src_data   = src_tab[src_addr[1:0]];
    assign src_data_w = src_addr_w + 8'h10;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int req_cnt = 0;
    logic [15:0] exp_wr_q[$];
    logic [15:0] exp_res_q[$];
    logic [15:0] wrap_q[$];
    int          res_cyc_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (req) req_cnt++;
        if (mem_wr_en) begin
            if (exp_wr_q.size() > 0) check("write", {mem_addr, mem_wr_data}, exp_wr_q.pop_front());
            else check("write_unexpected", 1, 0);
        end
        if (res_valid) begin
            res_cyc_q.push_back(cyc);
            if (exp_res_q.size() > 0) check("result", {res_addr, res_data}, exp_res_q.pop_front());
            else check("result_unexpected", 1, 0);
        end
        if (mem_wr_en_w) wrap_q.push_back({mem_addr_w, mem_wr_data_w});
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic push_load(input int n);
        for (int i = 0; i < n; i++) exp_wr_q.push_back({8'(i), src_tab[i]});
    endtask

    task automatic push_res();
        for (int k = 0; k < 2; k++) exp_res_q.push_back({8'(k), src_tab[k]});
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        while (!req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", req, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic do_done_run(input int after);
        int n;
        wait_req();
        repeat (after) @(posedge clk);
        #1 done = 1'b1;
        wait_idle(n);
        done = 1'b0;
    endtask

    task automatic check_reads();
        check("res_pending", exp_res_q.size(), 0);
        if (res_cyc_q.size() == 2) check("res_gap", res_cyc_q[1] - res_cyc_q[0], 1);
        else check("res_count", res_cyc_q.size(), 2);
        res_cyc_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int t;
        logic [15:0] exp_wrap [4];
        exp_wrap = '{16'hFE10, 16'hFF11, 16'h0012, 16'h0113};
        src_tab = '{8'h10, 8'h11, 8'h12, 8'h13};

        #12;
        check("rst_ctrl", {busy, req, mem_wr_en, res_valid, run_ok, timeout_err}, 0);
        check("rst_addr", {mem_addr, src_addr, res_addr}, 0);
        check("rst_count", cycle_count, 0);
        @(negedge clk) reset = 1'b1;

        // run 1: done in the 6th RUN cycle, start pulsed again while running
        push_load(4); push_res(); req_cnt = 0;
        pulse_start();
        wait_req();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(posedge clk);
        #1 done = 1'b1;
        wait_idle(n);
        done = 1'b0;
        check("r1_count", cycle_count, 6);
        check("r1_flags", {run_ok, timeout_err}, 2'b10);
        check("r1_req_pulses", req_cnt, 1);
        check("r1_writes_left", exp_wr_q.size(), 0);
        check_reads();
        repeat (3) @(negedge clk);
        check("r1_hold", {run_ok, timeout_err, cycle_count}, {2'b10, 16'd6});

        // run 2: new start clears flags; results AA, 55
        src_tab = '{8'hAA, 8'h55, 8'h33, 8'hCC};
        push_load(4); push_res(); req_cnt = 0;
        pulse_start();
        check("r2_flags_cleared", {busy, run_ok, timeout_err}, 3'b100);
        do_done_run(3);
        check("r2_count", cycle_count, 3);
        check("r2_flags", {run_ok, timeout_err}, 2'b10);
        check("r2_req_pulses", req_cnt, 1);
        check_reads();

        // run 3: done never comes, TIMEOUT=10
        src_tab = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_load(4); req_cnt = 0;
        pulse_start();
        wait_req();
        wait_idle(n);
        check("r3_launch_to_idle", n, 12);
        check("r3_flags", {run_ok, timeout_err}, 2'b01);
        check("r3_count", cycle_count, 10);
        check("r3_no_results", res_cyc_q.size(), 0);
        check("r3_req_pulses", req_cnt, 1);

        // run 4: done arrives in the same cycle the timeout would fire
        src_tab = '{8'h21, 8'h22, 8'h23, 8'h24};
        push_load(4); push_res();
        pulse_start();
        do_done_run(10);
        check("r4_count", cycle_count, 10);
        check("r4_flags", {run_ok, timeout_err}, 2'b10);
        check_reads();

        // run 5: reset in the second LOAD cycle
        src_tab = '{8'h31, 8'h32, 8'h33, 8'h34};
        exp_wr_q.push_back({8'h00, 8'h31}); req_cnt = 0;
        pulse_start();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_async_wr_en", mem_wr_en, 0);
        check("rst_async_ctrl", {busy, req, res_valid, run_ok, timeout_err, dbg_state}, 0);
        check("rst_async_addr", {mem_addr, src_addr, mem_wr_data}, 0);
        check("rst_async_count", cycle_count, 0);
        repeat (3) @(negedge clk);
        check("rst_no_req", req_cnt, 0);
        check("rst_writes_left", exp_wr_q.size(), 0);
        push_load(4); push_res();
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_after_release", {busy, mem_wr_en}, 2'b11);
        do_done_run(2);
        check("r5_count", cycle_count, 2);
        check("r5_flags", {run_ok, timeout_err}, 2'b10);
        check_reads();

        // wrapped load addresses on the second instance
        wrap_q.delete();
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        t = 0;
        while (busy_w && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("wrap_idle", busy_w, 0);
        check("wrap_writes", wrap_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < wrap_q.size()) check("wrap_addr_data", wrap_q[i], exp_wrap[i]);
        check("wrap_timeout", {run_ok_w, timeout_err_w}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
